bcd_stopwatch: RTL and testbench
================================

Name: bcd_stopwatch

Overview:
- Parametrised successor to the game-clock digit counter: an N-digit BCD elapsed/remaining-time counter with a programmable tick prescaler.
- Counts up or down and supports preload, run/halt, and wrap or saturate at the top.
- Down-count reaching zero raises a sticky expiry flag.
- Feeds the seven-segment display mux and the game FSM (round timer, time-out detection).

Parameters:
- CLK_DIV, 6500000, clk cycles per count tick (one tick = one least-significant digit step); legal range >= 2.
- NUM_DIGITS, 5, number of BCD digits; legal range 1..8.
- SATURATE, 0, up-count behaviour at all-9s: 0 = wrap to zero, 1 = hold at all-9s.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- run  input  1  1 = prescaler advances; 0 = halt, prescaler and count frozen.
- dir  input  1  0 = count up, 1 = count down.
- load  input  1  single-cycle request to preload count from load_value.
- load_value  input  4*NUM_DIGITS  BCD preload value; digit 0 is in bits [3:0].
- lap_req  input  1  capture request (see Optional Feature).
- count  output  4*NUM_DIGITS  registered BCD count.
- lap  output  4*NUM_DIGITS  captured count.
- tick  output  1  registered one-cycle pulse, high in the cycle count shows a new tick value.
- wrapped  output  1  one-cycle pulse on an up-count wrap from all-9s to zero.
- expired  output  1  sticky flag, set when a down-count reaches zero.

Behaviour:
- Reset values: count = 0, lap = 0, tick = 0, wrapped = 0, expired = 0, prescaler = 0.
- Priority per edge: reset > load > tick step.
- Prescaler:
  - When run=1, counts 0..CLK_DIV-1.
  - The internal step_en is high when run=1 and prescaler==CLK_DIV-1; the prescaler returns to 0 on that edge.
  - When run=0, the prescaler holds its value; halting does not lose a partial tick.
- Step:
  - On an edge with step_en=1, count takes count+1 (dir=0) or count-1 (dir=1) in BCD.
  - Carry/borrow ripples across all digits in the same cycle.
  - tick=1 in the following cycle, together with the new count.
  - Latency from step_en to the visible count is 1 cycle.
- Up boundary (count all 9s, dir=0):
  - SATURATE=0: count becomes 0 and wrapped pulses 1 cycle.
  - SATURATE=1: count holds, tick still pulses, wrapped stays 0.
- Down boundary:
  - A step from 1 to 0 sets expired.
  - A step with count==0 and dir=1 leaves count at 0 and keeps expired=1; there is no borrow wrap.
  - tick still pulses on these steps.
- expired clear:
  - Cleared by reset, by load, or by any up step.
  - A dir change alone does not clear it.
- Load:
  - count <= load_value, prescaler <= 0, expired <= 0, and tick/wrapped are suppressed that cycle.
  - Any load_value digit greater than 9 is clamped to 9 per digit.
  - Load is accepted whether run is 0 or 1.
- dir change mid-interval: takes effect at the next step; the prescaler is not disturbed.
- Reset mid-interval: all state returns to its reset values; the next step comes CLK_DIV cycles after reset deasserts while run=1.
- Every output is registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: BCD_STOPWATCH_LAP_EN.
- Defined:
  - lap_req=1 captures the count value present on that edge into lap, i.e. the value before any simultaneous step.
  - With load and lap_req on the same edge, lap takes the pre-load count.
  - lap holds until the next lap_req or reset.
- Undefined:
  - lap is tied to 0 and lap_req is ignored.
  - No capture register is synthesised.

Decomposition:
- Package bcd_stopwatch_pkg contains:
  - typedef bcd_digit_t (logic [3:0]);
  - constants BCD_MAX = 4'd9 and BCD_ZERO = 4'd0;
  - function bcd_clamp(bcd_digit_t) returning a value no greater than 9.
- Sub-module bcd_digit_step, instantiated NUM_DIGITS times in a generate chain:
  - inputs: digit, dir, carry_in;
  - outputs: next digit, carry_out;
  - purely combinational (9+1 -> 0 with carry; 0-1 -> 9 with borrow).
- Top-level holds the prescaler, the registers, the boundary logic and the lap capture.

Test Plan:
- Bench params CLK_DIV=4, NUM_DIGITS=3, SATURATE=0; reset then run=1, dir=0 -> count 000, 001, 002 with exactly 4 cycles between tick pulses; first tick 4 cycles after reset falls.
- Load 0x099, dir=0, one step -> count 0x100; then load 0x999, one step -> count 0x000 and wrapped pulses 1 cycle; with SATURATE=1 -> count stays 0x999 and wrapped=0.
- Load 0x002, dir=1 -> steps give 0x001, then 0x000 with expired=1; 3 further steps -> count 0x000, expired stays 1, tick pulses each step; load 0x050 -> expired=0.
- run=0 after 2 prescaler cycles, held 10 cycles, then run=1 -> next tick exactly 2 cycles later, count unchanged during the halt.
- Load 0xFA3 -> count 0x993 (per-digit clamp); load and step_en on the same edge -> count = loaded value and no tick the next cycle.
- With BCD_STOPWATCH_LAP_EN: count 0x042, lap_req on the step edge -> lap=0x042, count=0x043; reset mid-interval -> count, lap, expired all 0.

Source files
------------

// File: rtl/bcd_stopwatch_pkg.sv
// Shared BCD types, digit constants and the per-digit load clamp for bcd_stopwatch.
package bcd_stopwatch_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // Illegal BCD codes (A..F) saturate to 9.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the increment/decrement ripple chain; purely combinational.
module bcd_digit_step
  import bcd_stopwatch_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       dir,
  input  logic       carry_in,
  output bcd_digit_t next_digit,
  output logic       carry_out
);

  always_comb begin
    next_digit = digit;
    carry_out  = 1'b0;
    if (carry_in) begin
      if (!dir) begin
        if (digit >= BCD_MAX) begin
          next_digit = BCD_ZERO;
          carry_out  = 1'b1;
        end else begin
          next_digit = digit + 4'd1;
        end
      end else begin
        if (digit == BCD_ZERO) begin
          next_digit = BCD_MAX;
          carry_out  = 1'b1;
        end else begin
          next_digit = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// N-digit BCD up/down stopwatch with tick prescaler, preload, wrap/saturate and sticky expiry.
// Optional lap capture register enabled by defining BCD_STOPWATCH_LAP_EN.
module bcd_stopwatch
  import bcd_stopwatch_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 6500000,
  parameter int unsigned NUM_DIGITS = 5,
  parameter bit          SATURATE   = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    dir,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    lap_req,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [4*NUM_DIGITS-1:0] lap,
  output logic                    tick,
  output logic                    wrapped,
  output logic                    expired
);

  localparam int unsigned CW = 4 * NUM_DIGITS;
  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0]       presc;
  logic                step_en;
  logic [NUM_DIGITS:0] carry;
  logic [CW-1:0]       count_step;
  logic [CW-1:0]       load_clamped;
  logic [CW-1:0]       count_next;
  logic                wrap_next;
  logic                expired_next;

  assign step_en  = run && (presc == PRESC_LAST);
  assign carry[0] = 1'b1;

  // Ripple chain; the final carry flags all-9s (up) or all-0s (down).
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_step u_step (
      .digit      (count[4*g +: 4]),
      .dir        (dir),
      .carry_in   (carry[g]),
      .next_digit (count_step[4*g +: 4]),
      .carry_out  (carry[g+1])
    );
    assign load_clamped[4*g +: 4] = bcd_clamp(load_value[4*g +: 4]);
  end

  // Boundary handling: wrap or hold at all-9s, no borrow past zero.
  always_comb begin
    count_next   = count_step;
    wrap_next    = 1'b0;
    expired_next = expired;
    if (!dir) begin
      expired_next = 1'b0;
      if (carry[NUM_DIGITS]) begin
        if (SATURATE) count_next = count;
        else          wrap_next  = 1'b1;
      end
    end else begin
      if (carry[NUM_DIGITS]) begin
        count_next   = count;
        expired_next = 1'b1;
      end else if (count_step == '0) begin
        expired_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      count   <= '0;
      tick    <= 1'b0;
      wrapped <= 1'b0;
      expired <= 1'b0;
    end else if (load) begin
      presc   <= '0;
      count   <= load_clamped;
      tick    <= 1'b0;
      wrapped <= 1'b0;
      expired <= 1'b0;
    end else begin
      tick    <= step_en;
      wrapped <= step_en && wrap_next;
      if (run) presc <= step_en ? '0 : presc + PW'(1);
      if (step_en) begin
        count   <= count_next;
        expired <= expired_next;
      end
    end
  end

`ifdef BCD_STOPWATCH_LAP_EN
  // Captures the pre-step, pre-load count.
  always_ff @(posedge clk) begin
    if (reset)        lap <= '0;
    else if (lap_req) lap <= count;
  end
`else
  logic lap_req_unused;
  assign lap_req_unused = lap_req;
  assign lap            = '0;
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed, table-driven bench for bcd_stopwatch (CLK_DIV=4, 3 digits) plus a SATURATE=1 instance.
module tb_bcd_stopwatch;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned ND      = 3;
  localparam int unsigned CW      = 4 * ND;

  logic          clk = 1'b0;
  logic          reset, run, dir, load, lap_req;
  logic [CW-1:0] load_value;
  logic [CW-1:0] count, lap, count_s, lap_s;
  logic          tick, wrapped, expired, tick_s, wrapped_s, expired_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_stopwatch #(.CLK_DIV(CLK_DIV), .NUM_DIGITS(ND), .SATURATE(1'b0)) dut (
    .clk(clk), .reset(reset), .run(run), .dir(dir), .load(load),
    .load_value(load_value), .lap_req(lap_req), .count(count), .lap(lap),
    .tick(tick), .wrapped(wrapped), .expired(expired)
  );

  bcd_stopwatch #(.CLK_DIV(CLK_DIV), .NUM_DIGITS(ND), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .run(run), .dir(dir), .load(load),
    .load_value(load_value), .lap_req(lap_req), .count(count_s), .lap(lap_s),
    .tick(tick_s), .wrapped(wrapped_s), .expired(expired_s)
  );

  typedef struct {
    logic [CW-1:0] lv;
    logic          dir;
    int            steps;
    logic [CW-1:0] exp_count;
    logic          exp_expired;
    logic          exp_wrapped;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Load on one edge (prescaler returns to 0), so each step then takes CLK_DIV edges.
  task automatic do_load(input logic [CW-1:0] v, input logic d);
    dir        = d;
    load_value = v;
    load       = 1'b1;
    run        = 1'b1;
    cycles(1);
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; dir = 1'b0; load = 1'b0; lap_req = 1'b0;
    load_value = '0;

    vecs[0] = '{12'h099, 1'b0, 1, 12'h100, 1'b0, 1'b0};
    vecs[1] = '{12'h999, 1'b0, 1, 12'h000, 1'b0, 1'b1};
    vecs[2] = '{12'h002, 1'b1, 1, 12'h001, 1'b0, 1'b0};
    vecs[3] = '{12'h002, 1'b1, 2, 12'h000, 1'b1, 1'b0};
    vecs[4] = '{12'h002, 1'b1, 5, 12'h000, 1'b1, 1'b0};
    vecs[5] = '{12'hFA3, 1'b0, 0, 12'h993, 1'b0, 1'b0};
    vecs[6] = '{12'h129, 1'b0, 1, 12'h130, 1'b0, 1'b0};
    vecs[7] = '{12'h100, 1'b1, 1, 12'h099, 1'b0, 1'b0};
    vecs[8] = '{12'h000, 1'b1, 1, 12'h000, 1'b1, 1'b0};
    vecs[9] = '{12'h500, 1'b0, 3, 12'h503, 1'b0, 1'b0};

    // Reset state
    cycles(3);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_lap", 32'(lap), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_wrapped", 32'(wrapped), 32'h0);
    chk("rst_expired", 32'(expired), 32'h0);

    // Free run from reset: tick every CLK_DIV cycles, first one CLK_DIV after release
    reset = 1'b0; run = 1'b1; dir = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      cycles(1);
      chk($sformatf("run_tick_c%0d", c), 32'(tick), 32'((c % 4) == 0));
      chk($sformatf("run_count_c%0d", c), 32'(count), 32'(c / 4));
    end

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      do_load(vecs[i].lv, vecs[i].dir);
      cycles(CLK_DIV * vecs[i].steps);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_expired", i), 32'(expired), 32'(vecs[i].exp_expired));
      chk($sformatf("vec%0d_wrapped", i), 32'(wrapped), 32'(vecs[i].exp_wrapped));
      chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].steps > 0));
    end

    // Wrap versus saturate at all-9s; wrapped is a single-cycle pulse
    do_load(12'h999, 1'b0);
    cycles(CLK_DIV);
    chk("wrap_count", 32'(count), 32'h000);
    chk("wrap_pulse", 32'(wrapped), 32'h1);
    chk("sat_count", 32'(count_s), 32'h999);
    chk("sat_wrapped", 32'(wrapped_s), 32'h0);
    chk("sat_tick", 32'(tick_s), 32'h1);
    cycles(1);
    chk("wrap_pulse_end", 32'(wrapped), 32'h0);
    chk("wrap_tick_end", 32'(tick), 32'h0);

    // Expiry: dir change alone keeps it, an up step clears it, load clears it
    do_load(12'h001, 1'b1);
    cycles(CLK_DIV);
    chk("exp_set", 32'(expired), 32'h1);
    dir = 1'b0;
    cycles(2);
    chk("exp_dirchg_hold", 32'(expired), 32'h1);
    cycles(2);
    chk("exp_upstep_count", 32'(count), 32'h001);
    chk("exp_upstep_clear", 32'(expired), 32'h0);
    do_load(12'h002, 1'b1);
    cycles(2 * CLK_DIV);
    chk("exp_set2", 32'(expired), 32'h1);
    do_load(12'h050, 1'b1);
    chk("exp_load_clear", 32'(expired), 32'h0);
    chk("exp_load_count", 32'(count), 32'h050);

    // Halt after 2 prescaler cycles keeps the partial tick
    do_load(12'h000, 1'b0);
    cycles(2);
    run = 1'b0;
    cycles(10);
    chk("halt_count", 32'(count), 32'h000);
    chk("halt_tick", 32'(tick), 32'h0);
    run = 1'b1;
    cycles(1);
    chk("resume_tick_early", 32'(tick), 32'h0);
    cycles(1);
    chk("resume_tick", 32'(tick), 32'h1);
    chk("resume_count", 32'(count), 32'h001);

    // Load on the same edge as step_en wins and suppresses tick
    do_load(12'h000, 1'b0);
    cycles(CLK_DIV - 1);
    load_value = 12'h321;
    load = 1'b1;
    cycles(1);
    load = 1'b0;
    chk("ldstep_count", 32'(count), 32'h321);
    chk("ldstep_tick", 32'(tick), 32'h0);
    cycles(CLK_DIV - 1);
    chk("ldstep_nostep", 32'(count), 32'h321);
    cycles(1);
    chk("ldstep_next", 32'(count), 32'h322);

    // Lap capture on a step edge, then alongside a load
    do_load(12'h042, 1'b0);
    cycles(CLK_DIV - 1);
    lap_req = 1'b1;
    cycles(1);
    lap_req = 1'b0;
    chk("lap_step_count", 32'(count), 32'h043);
`ifdef BCD_STOPWATCH_LAP_EN
    chk("lap_step_lap", 32'(lap), 32'h042);
`else
    chk("lap_step_lap", 32'(lap), 32'h000);
`endif
    lap_req = 1'b1;
    do_load(12'h777, 1'b0);
    lap_req = 1'b0;
    chk("lap_load_count", 32'(count), 32'h777);
`ifdef BCD_STOPWATCH_LAP_EN
    chk("lap_load_lap", 32'(lap), 32'h043);
`else
    chk("lap_load_lap", 32'(lap), 32'h000);
`endif

    // Reset mid-interval with expired set
    do_load(12'h001, 1'b1);
    cycles(CLK_DIV + 2);
    chk("pre_rst_expired", 32'(expired), 32'h1);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    dir   = 1'b0;
    chk("mid_rst_count", 32'(count), 32'h000);
    chk("mid_rst_lap", 32'(lap), 32'h000);
    chk("mid_rst_expired", 32'(expired), 32'h0);
    chk("mid_rst_tick", 32'(tick), 32'h0);
    cycles(CLK_DIV - 1);
    chk("post_rst_tick_early", 32'(tick), 32'h0);
    cycles(1);
    chk("post_rst_tick", 32'(tick), 32'h1);
    chk("post_rst_count", 32'(count), 32'h001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
